mash_sequencer: RTL

- Controls the MASH sigma-delta DAC datapath: accepts input samples over a valid/ready handshake and holds each sample for OSR modulator ticks.
- Clears the MASH stage registers at start-up.
- Issues per-stage clock enables in pipeline order: stage k starts k cycles after stage 0 and stops k cycles after it.
- Sits between the sample source and the MASH stage chain.

---
 rtl/mash_pkg.sv | 21 ++
 rtl/mash_enable_pipe.sv | 33 +++
 rtl/mash_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH DAC sequencer.
package mash_pkg;

  localparam int MASH_DW     = 4;
  localparam int MASH_NSTAGE = 3;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN
  } mash_state_t;

  // Active stage count: 0 means one stage, anything above nstage saturates.
  function automatic logic [1:0] clamp_order(input logic [1:0] cfg, input int nstage);
    if (cfg == 2'd0) return 2'd1;
    if (int'(cfg) > nstage) return 2'(nstage);
    return cfg;
  endfunction

endpackage

// File: rtl/mash_enable_pipe.sv
// Per-stage clock enables: stage k follows stage 0 by k cycles, masked by order.
module mash_enable_pipe
  import mash_pkg::*;
#(
  parameter int NSTAGE = MASH_NSTAGE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        order,
  output logic [NSTAGE-1:0] stage_en
);

  logic [NSTAGE-1:1] pipe;
  logic [NSTAGE-1:0] full;

  assign full = {pipe, tick};

  // Shift the stage-0 enable down the chain one stage per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= full[NSTAGE-2:0];
  end

  // Stages at or beyond the active order never see an enable.
  always_comb begin
    stage_en = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (k < int'(order)) stage_en[k] = full[k];
    end
  end

endmodule

// File: rtl/mash_sequencer.sv
// Sample hold / stage sequencing controller sitting in front of the MASH chain.
module mash_sequencer
  import mash_pkg::*;
#(
  parameter int DW     = MASH_DW,
  parameter int OSR_W  = 8,
  parameter int NSTAGE = MASH_NSTAGE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [OSR_W-1:0]     osr_cfg,
  input  logic [1:0]           order_cfg,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] smp_out,
  output logic [NSTAGE-1:0]    stage_en,
  output logic                 stage_clr,
  output logic                 frame_start,
  output logic                 underrun,
  output logic                 busy
);

  localparam int CW = $clog2(NSTAGE) + 1;

  mash_state_t          state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [OSR_W-1:0]     phase;
  logic [OSR_W-1:0]     osr;
  logic [1:0]           order;
  logic signed [DW-1:0] hold;
  logic                 hold_full;
  logic                 boundary;
  logic                 tick;
  logic                 xfer;

  // State register; reset lands in IDLE immediately so enables drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the combinational control outputs.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    stage_clr = 1'b0;
    boundary  = 1'b0;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (en) state_nxt = FLUSH;
      end
      FLUSH: begin
        stage_clr = 1'b1;
        in_ready  = !hold_full;
        if (cnt == CW'(NSTAGE - 1)) state_nxt = RUN;
      end
      RUN: begin
        tick     = 1'b1;
        boundary = (phase == '0);
        in_ready = !hold_full || boundary;
        if (!en) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == CW'(NSTAGE - 2)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    xfer = in_valid && in_ready;
  end

  // Config latch, cycle/phase counters, holding buffer and sample output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      phase       <= '0;
      osr         <= OSR_W'(1);
      order       <= 2'd1;
      hold        <= '0;
      hold_full   <= 1'b0;
      smp_out     <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            cnt     <= '0;
            osr     <= (osr_cfg == '0) ? OSR_W'(1) : osr_cfg;
            order   <= clamp_order(order_cfg, NSTAGE);
            smp_out <= '0;
          end
        end
        FLUSH: begin
          cnt   <= cnt + CW'(1);
          phase <= '0;
          if (xfer) begin
            hold      <= in_data;
            hold_full <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            cnt       <= '0;
            hold_full <= 1'b0;
          end else begin
            phase <= (phase == osr - OSR_W'(1)) ? '0 : phase + OSR_W'(1);
            if (boundary) begin
              frame_start <= 1'b1;
              if (hold_full) smp_out  <= hold;
              else           underrun <= 1'b1;
              hold_full <= xfer;
              if (xfer) hold <= in_data;
            end else if (xfer) begin
              hold      <= in_data;
              hold_full <= 1'b1;
            end
          end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  mash_enable_pipe #(.NSTAGE(NSTAGE)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .order    (order),
    .stage_en (stage_en)
  );

endmodule
